// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command path: frame marker, parser state encoding
// and the frame checksum used by both the parser and the future response framer.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_e;

  function automatic logic [7:0] frame_csum(input logic [7:0] sync_b,
                                            input logic [7:0] addr_b,
                                            input logic [7:0] data_b);
    return sync_b ^ addr_b ^ data_b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and flags the
// cycle on which the count sits at CYCLES-1 (a clear in that same cycle suppresses it).
module uart_timeout_timer #(
  parameter int CYCLES = 100
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

  // next count: clear wins, wrap after expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {W{1'b0}};
    end else if (enable_i) begin
      if (cnt_q == LAST) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/ADDR/DATA/CSUM register-write frames from the uart_rx byte stream and
// issues registered write strobes, checksum-error and timeout pulses.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic       source_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_csum_err,
  output logic       o_timeout,
  output logic [7:0] o_err_count,
  output logic       o_busy
);

  localparam int TIMEOUT_CLKS = CLK_HZ / 1_000_000 * TIMEOUT_US;

  logic [1:0] rst_sync_q;
  logic       rst_n_s;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       csum_err_q, csum_err_d;
  logic       timeout_q, timeout_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       expire_s;

  // reset asserts asynchronously, releases on the clock
  always_ff @(posedge source_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  uart_timeout_timer #(
    .CYCLES (TIMEOUT_CLKS)
  ) u_timer (
    .clk_i    (source_clk),
    .rst_n_i  (rst_n_s),
    .clear_i  (i_rx_valid || (state_q == S_SYNC)),
    .enable_i (state_q != S_SYNC),
    .expire_o (expire_s)
  );

  // frame FSM, output and error-counter next state; a byte beats a same-cycle expiry
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    csum_err_d = 1'b0;
    timeout_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (i_rx_valid) begin
      case (state_q)
        S_SYNC: begin
          if (i_rx_byte == SYNC_BYTE) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_ADDR: begin
          addr_d  = i_rx_byte;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d  = i_rx_byte;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_SYNC;
          if (i_rx_byte == frame_csum(SYNC_BYTE, addr_q, data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            csum_err_d = 1'b1;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end else if (expire_s) begin
      state_d   = S_SYNC;
      timeout_d = 1'b1;
    end else begin
      state_d = state_q;
    end
    if ((csum_err_d || timeout_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // state and output registers
  always_ff @(posedge source_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= S_SYNC;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      csum_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      csum_err_q <= csum_err_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_csum_err  = csum_err_q;
  assign o_timeout   = timeout_q;
  assign o_err_count = err_cnt_q;
  assign o_busy      = (state_q != S_SYNC);

endmodule
